// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and access sequencer for the
// shared 128-bit-block main memory.
//
// Only one request is in flight at a time. After a request is accepted, the
// arbiter waits MEM_LATENCY cycles, performs the transfer (write strobe or
// read capture), and then pulses done to the port that owns the request.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req0_* / req1_*   per-port request: valid, write, addr (byte address,
//                     bits [3:0] ignored), wdata; responses accept, done,
//                     rdata (held until the next read on that port completes)
//   mem_read_write    single-cycle write strobe to mem
//   mem_address       block address to mem ([3:0] always 0)
//   mem_writeData     write block to mem
//   mem_readData      block returned by mem (combinational)
//   busy              high whenever a request is in flight
//
// Legal MEM_LATENCY range is 1..255.
module mem_arbiter #(
    parameter int MEM_LATENCY = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic         req0_write,
    input  logic [9:0]   req0_addr,
    input  logic [127:0] req0_wdata,
    output logic         req0_accept,
    output logic         req0_done,
    output logic [127:0] req0_rdata,
    input  logic         req1_valid,
    input  logic         req1_write,
    input  logic [9:0]   req1_addr,
    input  logic [127:0] req1_wdata,
    output logic         req1_accept,
    output logic         req1_done,
    output logic [127:0] req1_rdata,
    output logic         mem_read_write,
    output logic [9:0]   mem_address,
    output logic [127:0] mem_writeData,
    input  logic [127:0] mem_readData,
    output logic         busy
);
    // state | meaning
    // IDLE  | no request in flight; arbitrate and accept one
    // WAIT  | modelling memory latency, cnt counts down to 0
    // XFER  | one cycle: write strobe, or read data captured at its end
    // DONE  | one cycle: done pulse to the granted port
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(MEM_LATENCY - 1);

    state_t       state;
    state_t       state_nxt;
    logic         gnt;
    logic         wr;
    logic         last;
    logic [9:0]   addr;
    logic [127:0] wdata;
    logic [7:0]   cnt;
    logic [127:0] rdata0;
    logic [127:0] rdata1;
    logic         any_req;
    logic         sel;

    // On a tie the port that was not granted last wins; otherwise whichever
    // port is requesting.
    always_comb begin
        any_req = req0_valid | req1_valid;
        sel     = (req0_valid & req1_valid) ? ~last : req1_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        req0_accept    = 1'b0;
        req1_accept    = 1'b0;
        req0_done      = 1'b0;
        req1_done      = 1'b0;
        mem_read_write = 1'b0;
        busy           = (state != IDLE);
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt   = WAIT;
                    req0_accept = ~sel;
                    req1_accept = sel;
                end
            end
            WAIT: begin
                if (cnt == 8'd0) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                mem_read_write = wr;
                state_nxt      = DONE;
            end
            DONE: begin
                req0_done = ~gnt;
                req1_done = gnt;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A request being aborted by reset must not strobe mem or signal
        // completion, even in the cycle reset is first seen.
        if (reset) begin
            req0_accept    = 1'b0;
            req1_accept    = 1'b0;
            req0_done      = 1'b0;
            req1_done      = 1'b0;
            mem_read_write = 1'b0;
            busy           = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt    <= 1'b0;
            wr     <= 1'b0;
            last   <= 1'b1;
            addr   <= 10'd0;
            wdata  <= 128'd0;
            cnt    <= 8'd0;
            rdata0 <= 128'd0;
            rdata1 <= 128'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt   <= sel;
                        last  <= sel;
                        wr    <= sel ? req1_write : req0_write;
                        addr  <= (sel ? req1_addr : req0_addr) & 10'h3F0;
                        wdata <= sel ? req1_wdata : req0_wdata;
                        cnt   <= CNT_LOAD;
                    end
                end
                WAIT: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end
                end
                XFER: begin
                    if (!wr) begin
                        if (gnt) begin
                            rdata1 <= mem_readData;
                        end else begin
                            rdata0 <= mem_readData;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Address and data come straight from the grant latches, so they hold
    // their values through IDLE and DONE and are stable around the strobe.
    assign mem_address   = addr;
    assign mem_writeData = wdata;
    assign req0_rdata    = rdata0;
    assign req1_rdata    = rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int L = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1;
    logic         req0_valid = 1'b0, req0_write = 1'b0;
    logic [9:0]   req0_addr = '0;
    logic [127:0] req0_wdata = '0;
    logic         req0_accept, req0_done;
    logic [127:0] req0_rdata;
    logic         req1_valid = 1'b0, req1_write = 1'b0;
    logic [9:0]   req1_addr = '0;
    logic [127:0] req1_wdata = '0;
    logic         req1_accept, req1_done;
    logic [127:0] req1_rdata;
    logic         mem_read_write;
    logic [9:0]   mem_address;
    logic [127:0] mem_writeData, mem_readData;
    logic         busy;

    // environment memory (written by the DUT) and the model's shadow copy
    logic [31:0] mem    [0:255];
    logic [31:0] shadow [0:255];

    assign mem_readData = {mem[{mem_address[9:4], 2'd3}], mem[{mem_address[9:4], 2'd2}],
                           mem[{mem_address[9:4], 2'd1}], mem[{mem_address[9:4], 2'd0}]};

    mem_arbiter #(.MEM_LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_accept(req0_accept), .req0_done(req0_done),
        .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_accept(req1_accept), .req1_done(req1_done),
        .req1_rdata(req1_rdata),
        .mem_read_write(mem_read_write), .mem_address(mem_address),
        .mem_writeData(mem_writeData), .mem_readData(mem_readData), .busy(busy)
    );

    // second instance for the MEM_LATENCY=1 edge case
    logic         l_reset = 1'b1;
    logic         l_v0 = 1'b0, l_w0 = 1'b0;
    logic [9:0]   l_a0 = '0;
    logic [127:0] l_d0 = '0;
    logic         l_v1 = 1'b0, l_w1 = 1'b0;
    logic [9:0]   l_a1 = '0;
    logic [127:0] l_d1 = '0;
    logic         l_acc0, l_done0, l_acc1, l_done1, l_rw, l_busy;
    logic [127:0] l_rd0, l_rd1, l_wd;
    logic [9:0]   l_addr;
    logic [127:0] l_mrd = 128'h0;

    mem_arbiter #(.MEM_LATENCY(1)) dut_l1 (
        .clk(clk), .reset(l_reset),
        .req0_valid(l_v0), .req0_write(l_w0), .req0_addr(l_a0), .req0_wdata(l_d0),
        .req0_accept(l_acc0), .req0_done(l_done0), .req0_rdata(l_rd0),
        .req1_valid(l_v1), .req1_write(l_w1), .req1_addr(l_a1), .req1_wdata(l_d1),
        .req1_accept(l_acc1), .req1_done(l_done1), .req1_rdata(l_rd1),
        .mem_read_write(l_rw), .mem_address(l_addr), .mem_writeData(l_wd),
        .mem_readData(l_mrd), .busy(l_busy)
    );

    // behavioural model: k = cycles since the accept of the in-flight
    // request (-1 when nothing is in flight)
    int           k = -1;
    bit           mgnt = 1'b0, mwr = 1'b0, mlast = 1'b1;
    logic [9:0]   maddr = '0;
    logic [127:0] mwd = '0, mrd0 = '0, mrd1 = '0;

    int n_cmp = 0, n_fail = 0;
    int cyc = 0;
    bit hold0 = 1'b0, hold1 = 1'b0;
    int acc_port_q[$];
    int acc_cyc_q[$];
    int done_cyc[2] = '{-1, -1};
    int done_cnt[2] = '{0, 0};
    int wr_cnt = 0, wr_cyc = -1;
    logic [9:0] wr_addr = '0;
    int l_acc_cyc = -1, l_rw_cyc = -1, l_done_cyc = -1, l_done_cnt = 0, l_rw_cnt = 0, l_p1_cnt = 0;

    function automatic logic [127:0] shadow_blk(logic [9:0] a);
        return {shadow[{a[9:4], 2'd3}], shadow[{a[9:4], 2'd2}],
                shadow[{a[9:4], 2'd1}], shadow[{a[9:4], 2'd0}]};
    endfunction

    task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // one clock cycle: compare at negedge, advance model at posedge
    task automatic step();
        bit           e_acc0, e_acc1, g, any, do_w, l_drop;
        logic [9:0]   w_a;
        logic [127:0] w_d;
        @(negedge clk);
        any    = req0_valid || req1_valid;
        g      = (req0_valid && req1_valid) ? !mlast : req1_valid;
        e_acc0 = !reset && (k < 0) && any && !g;
        e_acc1 = !reset && (k < 0) && any && g;
        chk("accept0", req0_accept, e_acc0);
        chk("accept1", req1_accept, e_acc1);
        chk("done0", req0_done, !reset && (k == L + 2) && !mgnt);
        chk("done1", req1_done, !reset && (k == L + 2) && mgnt);
        chk("mem_read_write", mem_read_write, !reset && (k == L + 1) && mwr);
        chk("busy", busy, !reset && (k >= 1));
        chk("mem_address", mem_address, maddr);
        chk("mem_writeData", mem_writeData, mwd);
        chk("rdata0", req0_rdata, mrd0);
        chk("rdata1", req1_rdata, mrd1);
        if (req0_accept) begin acc_port_q.push_back(0); acc_cyc_q.push_back(cyc); end
        if (req1_accept) begin acc_port_q.push_back(1); acc_cyc_q.push_back(cyc); end
        if (req0_done) begin done_cyc[0] = cyc; done_cnt[0]++; end
        if (req1_done) begin done_cyc[1] = cyc; done_cnt[1]++; end
        if (mem_read_write) begin wr_cnt++; wr_cyc = cyc; wr_addr = mem_address; end
        do_w = mem_read_write;
        w_a  = mem_address;
        w_d  = mem_writeData;
        l_drop = l_acc0;
        if (l_acc0) l_acc_cyc = cyc;
        if (l_rw) begin l_rw_cyc = cyc; l_rw_cnt++; end
        if (l_done0) begin l_done_cyc = cyc; l_done_cnt++; end
        if (l_acc1 || l_done1) l_p1_cnt++;
        @(posedge clk);
        if (do_w) begin
            for (int i = 0; i < 4; i++) mem[{w_a[9:4], 2'(i)}] = w_d[32*i +: 32];
        end
        if (reset) begin
            k = -1; mlast = 1'b1; mgnt = 1'b0; mwr = 1'b0;
            maddr = '0; mwd = '0; mrd0 = '0; mrd1 = '0;
        end else if (e_acc0 || e_acc1) begin
            k     = 1;
            mgnt  = g;
            mlast = g;
            mwr   = g ? req1_write : req0_write;
            maddr = (g ? req1_addr : req0_addr) & 10'h3F0;
            mwd   = g ? req1_wdata : req0_wdata;
        end else if (k >= 1) begin
            if (k == L + 1) begin
                if (mwr) begin
                    for (int i = 0; i < 4; i++) shadow[{maddr[9:4], 2'(i)}] = mwd[32*i +: 32];
                end else if (mgnt) begin
                    mrd1 = shadow_blk(maddr);
                end else begin
                    mrd0 = shadow_blk(maddr);
                end
            end
            k = (k == L + 2) ? -1 : k + 1;
        end
        #1;
        cyc++;
        if (e_acc0 && !hold0) req0_valid = 1'b0;
        if (e_acc1 && !hold1) req1_valid = 1'b0;
        if (l_drop) l_v0 = 1'b0;
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int a, b, d0, wc, dc1;
    logic [127:0] blk;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            shadow[i] = mem[i];
        end
        mem[8'h14] = 32'h44444444; mem[8'h15] = 32'h33333333;
        mem[8'h16] = 32'h22222222; mem[8'h17] = 32'h11111111;
        for (int i = 8'h14; i <= 8'h17; i++) shadow[i] = mem[i];
        @(posedge clk); #1;
        steps(2);
        chk("reset_busy", busy, 1'b0);
        chk("reset_mem_address", mem_address, 10'h000);

        // single read on port 0; latency-1 write on the second instance
        reset = 1'b0;
        l_reset = 1'b0;
        l_v0 = 1'b1; l_w0 = 1'b1; l_a0 = 10'h04C; l_d0 = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 10'h05A;
        a = cyc; wc = wr_cnt;
        step();
        chk("read_mem_address_A1", mem_address, 10'h050);
        steps(6);
        chk("read_accept_cycle", acc_cyc_q[0], a);
        chk("read_done_cycle", done_cyc[0], a + 6);
        chk("read_done_count", done_cnt[0], 1);
        chk("read_rdata", req0_rdata, 128'h11111111_22222222_33333333_44444444);
        chk("read_no_strobe", wr_cnt, wc);
        chk("lat1_xfer_cycle", l_rw_cyc, l_acc_cyc + 2);
        chk("lat1_done_cycle", l_done_cyc, l_acc_cyc + 3);
        chk("lat1_accept_cycle", l_acc_cyc, a);
        chk("lat1_counts", {l_rw_cnt[7:0], l_done_cnt[7:0], l_p1_cnt[7:0]}, {8'd1, 8'd1, 8'd0});
        chk("lat1_idle_outputs", {l_busy, l_addr, l_rd0, l_rd1}, {1'b0, 10'h040, 128'h0, 128'h0});
        chk("lat1_wdata", l_wd, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666);

        // single write on port 1, then read it back
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 10'h3F7;
        req1_wdata = 128'hDEADBEEF_00000001_00000002_00000003;
        a = cyc; wc = wr_cnt;
        steps(7);
        chk("write_strobe_count", wr_cnt - wc, 1);
        chk("write_strobe_cycle", wr_cyc, a + 5);
        chk("write_strobe_addr", wr_addr, 10'h3F0);
        chk("write_done_cycle", done_cyc[1], a + 6);
        chk("write_mem_word_ff", mem[8'hFF], 32'hDEADBEEF);
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 10'h3F0;
        steps(7);
        chk("readback_rdata", req1_rdata, 128'hDEADBEEF_00000001_00000002_00000003);

        // simultaneous requests held valid from reset release
        reset = 1'b1;
        step();
        reset = 1'b0;
        hold0 = 1'b1; hold1 = 1'b1;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 10'h120;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 10'h230;
        b = acc_port_q.size();
        steps(28);
        hold0 = 1'b0; hold1 = 1'b0;
        steps(45);
        if (acc_port_q.size() < b + 4) begin
            n_cmp++; n_fail++;
            $display("FAIL tie_grant_count: got %0d expected at least 4", acc_port_q.size() - b);
        end else begin
            for (int i = 0; i < 4; i++) chk("tie_grant_port", acc_port_q[b + i], i % 2);
            for (int i = 1; i < 4; i++) chk("tie_spacing", acc_cyc_q[b + i] - acc_cyc_q[b + i - 1], 7);
        end

        // back-to-back on port 0, then port 1 arriving during port 0's WAIT
        b = acc_port_q.size();
        hold0 = 1'b1;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 10'h100;
        steps(7);
        d0 = done_cyc[0];
        steps(2);
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 10'h200;
        steps(6);
        hold0 = 1'b0;
        steps(14);
        if (acc_port_q.size() < b + 4) begin
            n_cmp++; n_fail++;
            $display("FAIL b2b_grant_count: got %0d expected 4", acc_port_q.size() - b);
        end else begin
            chk("b2b_second_accept", acc_cyc_q[b + 1], d0 + 1);
            chk("b2b_second_port", acc_port_q[b + 1], 0);
            chk("b2b_port1_first", acc_port_q[b + 2], 1);
            chk("b2b_port0_after", acc_port_q[b + 3], 0);
        end

        // reset during WAIT of a write
        hold1 = 1'b1;
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 10'h12C;
        blk = {$urandom, $urandom, $urandom, $urandom};
        req1_wdata = blk;
        wc = wr_cnt; dc1 = done_cnt[1];
        steps(3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        hold1 = 1'b0;
        chk("abort_outputs", {busy, mem_read_write, req0_done, req1_done, mem_address},
            {1'b0, 1'b0, 1'b0, 1'b0, 10'h000});
        chk("abort_data", {req0_rdata, req1_rdata}, 256'h0);
        chk("abort_writedata", mem_writeData, 128'h0);
        chk("abort_no_strobe", wr_cnt, wc);
        chk("abort_no_done", done_cnt[1], dc1);
        steps(8);
        chk("reissue_strobe", wr_cnt - wc, 1);
        chk("reissue_done", done_cnt[1] - dc1, 1);
        chk("reissue_mem", {mem[8'h4B], mem[8'h4A], mem[8'h49], mem[8'h48]}, blk);

        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            if (!req0_valid && $urandom_range(0, 3) == 0) begin
                req0_valid = 1'b1; req0_write = 1'($urandom_range(0, 1));
                req0_addr = 10'($urandom_range(0, 1023));
                req0_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!req1_valid && $urandom_range(0, 3) == 0) begin
                req1_valid = 1'b1; req1_write = 1'($urandom_range(0, 1));
                req1_addr = 10'($urandom_range(0, 1023));
                req1_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            reset = ($urandom_range(0, 149) == 0);
            step();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
